pc_unit_ras: RTL

//  Parametrised program-counter unit for the KGPRisc fetch stage. Adds stall, PC-relative branch,

---
 rtl/pc_pkg.sv | 18 +
 rtl/ras_stack.sv | 62 ++++++
 rtl/pc_unit_ras.sv | 97 +++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared PC-stage definitions: winning-action encoding and default geometry.
package pc_pkg;

  localparam int unsigned PC_W = 32;
  localparam int unsigned PC_STEP = 1;
  localparam logic [PC_W-1:0] PC_RESET_VEC = '1;

  // Action selected for the next PC update; exactly one wins each edge.
  typedef enum logic [2:0] {
    PC_ACT_SEQ,
    PC_ACT_BRANCH,
    PC_ACT_JUMP,
    PC_ACT_CALL,
    PC_ACT_RET,
    PC_ACT_HOLD
  } pc_act_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full silently replaces the oldest entry.
module ras_stack #(
  parameter int unsigned W         = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           hold,
  input  logic                           push,
  input  logic                           pop,
  input  logic [W-1:0]                   push_data,
  output logic [W-1:0]                   top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] count,
  output logic                           empty,
  output logic                           full,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

  logic [W-1:0]    mem_q [RAS_DEPTH];
  logic [PtrW-1:0] top_q;
  logic [PtrW-1:0] wr_ptr;
  logic [CntW-1:0] count_q;
  logic            do_push;
  logic            do_pop;

  // Decode the effective operation and the status strobes.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CntW'(RAS_DEPTH));
    do_push   = push & ~hold;
    do_pop    = pop & ~hold & ~push & ~empty;
    wr_ptr    = top_q + PtrW'(1);
    overflow  = do_push & full;
    underflow = pop & ~hold & ~push & empty;
    top       = mem_q[top_q];
    count     = count_q;
  end

  // Top pointer and occupancy; pointer wraps naturally since depth is a power of two.
  always_ff @(negedge clk) begin
    if (reset) begin
      top_q   <= '0;
      count_q <= '0;
    end else if (do_push) begin
      top_q <= wr_ptr;
      if (!full) count_q <= count_q + CntW'(1);
    end else if (do_pop) begin
      top_q   <= top_q - PtrW'(1);
      count_q <= count_q - CntW'(1);
    end
  end

  // Entry storage; contents after reset are don't-care.
  always_ff @(negedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with stall, branch, jump and call/return via a RAS.
module pc_unit_ras
  import pc_pkg::*;
#(
  parameter int unsigned W         = PC_W,
  parameter int unsigned STEP      = PC_STEP,
  parameter logic [W-1:0] RESET_VEC = '1,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_en,
  input  logic [W-1:0]                   branch_off,
  input  logic                           jump_en,
  input  logic [W-1:0]                   jump_addr,
  input  logic                           call_en,
  input  logic [W-1:0]                   call_addr,
  input  logic                           ret_en,
  output logic [W-1:0]                   pc,
  output logic [W-1:0]                   pc_link,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  pc_act_e      act;
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;
  logic [W-1:0] ras_top;
  logic         ovf_strobe;
  logic         unf_strobe;
  logic         ovf_q;
  logic         unf_q;

  // Priority encoder: stall > ret > call > jump > branch > sequential.
  always_comb begin
    act = PC_ACT_SEQ;
    if (stall)          act = PC_ACT_HOLD;
    else if (ret_en)    act = PC_ACT_RET;
    else if (call_en)   act = PC_ACT_CALL;
    else if (jump_en)   act = PC_ACT_JUMP;
    else if (branch_en) act = PC_ACT_BRANCH;
  end

  ras_stack #(
    .W        (W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .hold     (act == PC_ACT_HOLD),
    .push     (act == PC_ACT_CALL),
    .pop      (act == PC_ACT_RET),
    .push_data(pc_link),
    .top      (ras_top),
    .count    (ras_count),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ovf_strobe),
    .underflow(unf_strobe)
  );

  // Next-PC mux; a return on an empty stack falls through to sequential.
  always_comb begin
    pc_link = pc_q + W'(STEP);
    pc_d    = pc_link;
    unique case (act)
      PC_ACT_HOLD:   pc_d = pc_q;
      PC_ACT_RET:    pc_d = ras_empty ? pc_link : ras_top;
      PC_ACT_CALL:   pc_d = call_addr;
      PC_ACT_JUMP:   pc_d = jump_addr;
      PC_ACT_BRANCH: pc_d = pc_link + branch_off;
      default:       pc_d = pc_link;
    endcase
  end

  // PC register and sticky stack-error flags, cleared only by reset.
  always_ff @(negedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_q | ovf_strobe;
      unf_q <= unf_q | unf_strobe;
    end
  end

  assign pc            = pc_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
